// File: rtl/tap_controller_pkg.sv
// IEEE 1149.1 TAP state encodings shared by the TAP controller.
package as_pack;

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_t;

endpackage

// File: rtl/tap_controller.sv
// JTAG TAP state machine: decodes TMS into IR/DR chain strobes and muxes TDO.
// Optional JTAG_TDO_NEGEDGE_EN registers tdo_o/tdo_en_o on the falling edge of TCK.
module tap_controller
  import as_pack::*;
#(
  parameter logic TDO_IDLE = 1'b0
) (
  input  logic tck_i,
  input  logic trst_i,
  input  logic tms_i,
  input  logic ir_ser_i,
  input  logic dr_ser_i,
  output logic tlr_o,
  output logic ir_shift_o,
  output logic ir_clock_o,
  output logic ir_upd_o,
  output logic dr_shift_o,
  output logic dr_clock_o,
  output logic dr_upd_o,
  output logic sel_ir_o,
  output logic tdo_en_o,
  output logic tdo_o
);

  tap_state_t r_state;
  tap_state_t w_next;
  logic       w_tdo_en;
  logic       w_tdo;

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) r_state <= TLR;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = TLR;
    case (r_state)
      TLR:    w_next = tms_i ? TLR    : RTI;
      RTI:    w_next = tms_i ? SEL_DR : RTI;
      SEL_DR: w_next = tms_i ? SEL_IR : CAP_DR;
      CAP_DR: w_next = tms_i ? EX1_DR : SH_DR;
      SH_DR:  w_next = tms_i ? EX1_DR : SH_DR;
      EX1_DR: w_next = tms_i ? UPD_DR : PAU_DR;
      PAU_DR: w_next = tms_i ? EX2_DR : PAU_DR;
      EX2_DR: w_next = tms_i ? UPD_DR : SH_DR;
      UPD_DR: w_next = tms_i ? SEL_DR : RTI;
      SEL_IR: w_next = tms_i ? TLR    : CAP_IR;
      CAP_IR: w_next = tms_i ? EX1_IR : SH_IR;
      SH_IR:  w_next = tms_i ? EX1_IR : SH_IR;
      EX1_IR: w_next = tms_i ? UPD_IR : PAU_IR;
      PAU_IR: w_next = tms_i ? EX2_IR : PAU_IR;
      EX2_IR: w_next = tms_i ? UPD_IR : SH_IR;
      UPD_IR: w_next = tms_i ? SEL_DR : RTI;
    endcase
  end

  always_comb begin
    tlr_o      = (r_state == TLR);
    ir_shift_o = (r_state == SH_IR);
    ir_clock_o = (r_state == CAP_IR) || (r_state == SH_IR);
    ir_upd_o   = (r_state == UPD_IR);
    dr_shift_o = (r_state == SH_DR);
    dr_clock_o = (r_state == CAP_DR) || (r_state == SH_DR);
    dr_upd_o   = (r_state == UPD_DR);
    sel_ir_o   = 1'b0;
    case (r_state)
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR: sel_ir_o = 1'b1;
      default:                                               sel_ir_o = 1'b0;
    endcase
  end

  always_comb begin
    w_tdo_en = (r_state == SH_IR) || (r_state == SH_DR);
    w_tdo    = TDO_IDLE;
    if (w_tdo_en) w_tdo = sel_ir_o ? ir_ser_i : dr_ser_i;
  end

`ifdef JTAG_TDO_NEGEDGE_EN
  logic r_tdo;
  logic r_tdo_en;

  always_ff @(negedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      r_tdo    <= TDO_IDLE;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo    <= w_tdo;
      r_tdo_en <= w_tdo_en;
    end
  end

  assign tdo_o    = r_tdo;
  assign tdo_en_o = r_tdo_en;
`else
  assign tdo_o    = w_tdo;
  assign tdo_en_o = w_tdo_en;
`endif

endmodule

// File: tb/tb_tap_controller.sv
// Scoreboard bench for tap_controller: expected outputs are queued per TMS step
// from an independent table model and compared after the clock edges.
module tb_tap_controller;

  localparam logic TB_TDO_IDLE = 1'b0;

  logic tck = 1'b0;
  logic trst_i, tms_i, ir_ser_i, dr_ser_i;
  logic tlr_o, ir_shift_o, ir_clock_o, ir_upd_o, dr_shift_o, dr_clock_o, dr_upd_o;
  logic sel_ir_o, tdo_en_o, tdo_o;

  tap_controller #(.TDO_IDLE(TB_TDO_IDLE)) dut (
    .tck_i(tck), .trst_i(trst_i), .tms_i(tms_i), .ir_ser_i(ir_ser_i), .dr_ser_i(dr_ser_i),
    .tlr_o(tlr_o), .ir_shift_o(ir_shift_o), .ir_clock_o(ir_clock_o), .ir_upd_o(ir_upd_o),
    .dr_shift_o(dr_shift_o), .dr_clock_o(dr_clock_o), .dr_upd_o(dr_upd_o),
    .sel_ir_o(sel_ir_o), .tdo_en_o(tdo_en_o), .tdo_o(tdo_o)
  );

  always #5 tck = ~tck;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] ns0 [16];
  logic [3:0] ns1 [16];
  logic [3:0] m_state;
  logic [9:0] sb [$];
  string      paths [16];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (model state %h) at %0t", tag, obs, exp, m_state, $time);
    end
  endtask

  // {tlr, ir_shift, ir_clock, ir_upd, dr_shift, dr_clock, dr_upd, sel_ir, tdo_en, tdo}
  function automatic logic [9:0] exp_out(input logic [3:0] st, input logic irs, input logic drs);
    logic sel, en, td;
    sel = (st == 4'h4) || (st == 4'hE) || (st == 4'hA) || (st == 4'h9) ||
          (st == 4'hB) || (st == 4'h8) || (st == 4'hD);
    en  = (st == 4'hA) || (st == 4'h2);
    td  = en ? (sel ? irs : drs) : TB_TDO_IDLE;
    return {st == 4'hF, st == 4'hA, (st == 4'hE) || (st == 4'hA), st == 4'hD,
            st == 4'h2, (st == 4'h6) || (st == 4'h2), st == 4'h5, sel, en, td};
  endfunction

  function automatic logic [9:0] dut_out();
    return {tlr_o, ir_shift_o, ir_clock_o, ir_upd_o, dr_shift_o, dr_clock_o, dr_upd_o,
            sel_ir_o, tdo_en_o, tdo_o};
  endfunction

  // Called just after a falling edge: drive, predict, compare strobes after the
  // rising edge and TDO after the following falling edge.
  task automatic step(input logic tms, input logic irs, input logic drs, input string tag);
    logic [9:0] e;
    logic [9:0] o;
    tms_i = tms; ir_ser_i = irs; dr_ser_i = drs;
    m_state = tms ? ns1[m_state] : ns0[m_state];
    sb.push_back(exp_out(m_state, irs, drs));
    @(posedge tck); #1;
    e = sb.pop_front();
    o = dut_out();
    chk({tag, "/strobes"}, {8'h00, o[9:2]}, {8'h00, e[9:2]});
    @(negedge tck); #1;
    o = dut_out();
    chk({tag, "/tdo"}, {14'h0, o[1:0]}, {14'h0, e[1:0]});
  endtask

  task automatic to_tlr(input string tag);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, tag);
  endtask

  initial begin
    ns0[4'hF] = 4'hC; ns1[4'hF] = 4'hF;
    ns0[4'hC] = 4'hC; ns1[4'hC] = 4'h7;
    ns0[4'h7] = 4'h6; ns1[4'h7] = 4'h4;
    ns0[4'h4] = 4'hE; ns1[4'h4] = 4'hF;
    ns0[4'h6] = 4'h2; ns1[4'h6] = 4'h1;
    ns0[4'h2] = 4'h2; ns1[4'h2] = 4'h1;
    ns0[4'h1] = 4'h3; ns1[4'h1] = 4'h5;
    ns0[4'h3] = 4'h3; ns1[4'h3] = 4'h0;
    ns0[4'h0] = 4'h2; ns1[4'h0] = 4'h5;
    ns0[4'h5] = 4'hC; ns1[4'h5] = 4'h7;
    ns0[4'hE] = 4'hA; ns1[4'hE] = 4'h9;
    ns0[4'hA] = 4'hA; ns1[4'hA] = 4'h9;
    ns0[4'h9] = 4'hB; ns1[4'h9] = 4'hD;
    ns0[4'hB] = 4'hB; ns1[4'hB] = 4'h8;
    ns0[4'h8] = 4'hA; ns1[4'h8] = 4'hD;
    ns0[4'hD] = 4'hC; ns1[4'hD] = 4'h7;
    paths[0]  = "";        paths[1]  = "0";       paths[2]  = "01";      paths[3]  = "010";
    paths[4]  = "0100";    paths[5]  = "0101";    paths[6]  = "01010";   paths[7]  = "010101";
    paths[8]  = "01011";   paths[9]  = "011";     paths[10] = "0110";    paths[11] = "01100";
    paths[12] = "01101";   paths[13] = "011010";  paths[14] = "0110101"; paths[15] = "011011";

    trst_i = 1'b1; tms_i = 1'b1; ir_ser_i = 1'b0; dr_ser_i = 1'b0;
    m_state = 4'hF;
    #1;
    chk("reset_state", {6'h0, dut_out()}, {6'h0, exp_out(4'hF, 1'b0, 1'b0)});
    @(negedge tck); #1;
    trst_i = 1'b0;

    // IR path into SH_IR, shift 1,0,1,1, then exit and update.
    step(1'b0, 1'b0, 1'b0, "t3_rti");
    step(1'b1, 1'b0, 1'b0, "t3_seldr");
    step(1'b1, 1'b0, 1'b0, "t3_selir");
    step(1'b0, 1'b0, 1'b0, "t3_capir");
    step(1'b0, 1'b1, 1'b0, "t3_shir");
    step(1'b0, 1'b1, 1'b0, "t4_sh1");
    step(1'b0, 1'b0, 1'b1, "t4_sh0");
    step(1'b0, 1'b1, 1'b0, "t4_sh1b");
    step(1'b0, 1'b1, 1'b0, "t4_sh1c");
    step(1'b1, 1'b0, 1'b0, "t4_ex1ir");
    step(1'b1, 1'b0, 1'b0, "t4_updir");
    step(1'b1, 1'b0, 1'b0, "t6_seldr");
    step(1'b0, 1'b0, 1'b0, "t6_capdr");
    step(1'b1, 1'b0, 1'b0, "t6_ex1dr");
    step(1'b0, 1'b0, 1'b0, "t6_paudr");
    step(1'b1, 1'b0, 1'b0, "t6_ex2dr");
    step(1'b1, 1'b0, 1'b0, "t6_upddr");
    step(1'b0, 1'b0, 1'b0, "t5_rti");

    // DR path: RTI -> SH_DR with changing dr_ser, pause and resume.
    step(1'b1, 1'b0, 1'b0, "t5_seldr");
    step(1'b0, 1'b0, 1'b0, "t5_capdr");
    step(1'b0, 1'b0, 1'b1, "t5_shdr");
    step(1'b0, 1'b1, 1'b0, "t5_shdr0");
    step(1'b0, 1'b0, 1'b1, "t5_shdr1");
    step(1'b1, 1'b0, 1'b1, "t5_ex1dr");
    step(1'b0, 1'b0, 1'b1, "t5_paudr");
    step(1'b1, 1'b0, 1'b1, "t5_ex2dr");
    step(1'b0, 1'b1, 1'b1, "t5_shdr_again");

    // Asynchronous reset mid-SH_DR, between clock edges.
    #2;
    trst_i = 1'b1;
    #1;
    chk("trst_mid_shift", {6'h0, dut_out()}, {6'h0, exp_out(4'hF, 1'b0, 1'b0)});
    tms_i = 1'b1;
    trst_i = 1'b0;
    m_state = 4'hF;
    @(negedge tck); #1;
    chk("trst_hold_tlr", {6'h0, dut_out()}, {6'h0, exp_out(4'hF, 1'b0, 1'b0)});

    // From every state, five TMS=1 edges return to TLR.
    for (int t = 0; t < 16; t++) begin
      to_tlr("t2_pre");
      for (int i = 0; i < paths[t].len(); i++)
        step(paths[t][i] == 8'h31, 1'b1, 1'b1, "t2_path");
      to_tlr("t2_tms1x5");
    end

    if (sb.size() != 0) chk("sb_drained", 16'(sb.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
